wb_fibo_ctrl: RTL
=================

# wb_fibo_ctrl

Parametrised Wishbone classic slave that controls and observes NUM_CH Fibonacci generator channels from the Caravel management core. Each channel gets its own clock divider select, an enable switch and a readable result value. The block adds a FIFO mailbox, interrupt status/enable with an irq line, and a sticky panic that forces every channel off. Acknowledge is registered: exactly one ack pulse per transfer.

## Interface
- BASE_ADDRESS, 32'h3000_0000, base of the register window
- CLOCK_WIDTH, 6, width of each channel's clock_op field (1..32)
- NUM_CH, 2, number of channels (1..8)
- VAL_WIDTH, 30, width of each channel value input (1..32)
- FIFO_DEPTH, 4, mailbox entries; power of two, 2..16
- ID, 32'h4669626f, value returned by the ID register
- wb_clk_i  in  1  clock
- reset  in  1  reset reset, synchronous, active-high; clock wb_clk_i
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe, cycle, write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32  address, write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  read data, valid only while ack is high, else 0
- val_in  in  NUM_CH*VAL_WIDTH  channel values; channel c at [c*VAL_WIDTH +: VAL_WIDTH]
- clock_op  out  NUM_CH*CLOCK_WIDTH  per-channel clock select, same packing
- switch_out  out  NUM_CH  per-channel enable
- irq_o  out  1  level interrupt

## Operation
- Window: BASE_ADDRESS to BASE_ADDRESS+0x20+8*NUM_CH-1, word aligned. Addresses outside the window are never acked.
- Offset map:
  - 0x00 INFO, RO: {8'(NUM_CH), 8'(FIFO_DEPTH), 16'(0x08+2*NUM_CH)}.
  - 0x04 ID, RO.
  - 0x08 IRQ_STATUS: bit0 fifo_nonempty (live), bit1 overflow (sticky; W1C), bit2 panic (live).
  - 0x0C IRQ_EN, RW [2:0]; reset 0.
  - 0x10 SWITCH, RW [NUM_CH-1:0]; reset all ones.
  - 0x14 FIFO_DATA: a write pushes. A read pops and returns the head. A read while empty returns 32'hf00df00d and does not pop.
  - 0x18 FIFO_STATUS, RO: {count in bits [8:4], full in bit 1, empty in bit 0}.
  - 0x1C PANIC: any write sets panic and pushes nothing. A read returns {31'b0,panic}. Only reset clears panic.
  - 0x20+8c CLOCK[c], RW [CLOCK_WIDTH-1:0]; reset 1.
  - 0x24+8c VAL[c], RO: val_in channel c zero-extended, sampled on the ack edge.
- In-window holes: reads return 0, writes are ignored; both are acked.
- Writes take effect only when wbs_sel_i==4'hF. Other sel values are still acked, with no side effect. Reads ignore sel.
- Push while full: data dropped, overflow set, count unchanged.
- switch_out = panic ? 0 : SWITCH.
- irq_o = |(IRQ_STATUS & IRQ_EN), registered.
- Reset values of outputs: ack 0, dat_o 0, irq_o 0, clock_op each 1, switch_out all ones. Reset also empties the FIFO and clears overflow and panic.

## Timing
- Request condition: stb & cyc & in-window & !ack. It is sampled at edge N; ack and dat_o are high for the cycle after N, then ack returns to 0 at edge N+1.
- Back-to-back transfers held by the master therefore ack every other cycle.
- Side effects occur once per transfer, at edge N: register write, push, pop, W1C, panic set. Holding stb across the ack cycle must not repeat them.
- FIFO is circular with log2(FIFO_DEPTH)-bit pointers that wrap. Count is 0..FIFO_DEPTH; full when count==FIFO_DEPTH.
- irq_o reflects an event one cycle after the status changes; it is high by the edge after ack at the latest.
- Dropping stb/cyc while the request is pending does not cancel it: the registered ack still pulses once.
- Reset asserted mid-transfer: ack forced 0 on the next edge, the transfer is lost with no side effect, and the master retries.

## Test plan
- Reset, then read INFO, ID, CLOCK[0], SWITCH with NUM_CH=2, FIFO_DEPTH=4 -> 0x0204000C, 0x4669626f, 0x1, 0x3; each ack is exactly 1 cycle, 1 cycle after stb.
- Push 0xA,0xB,0xC,0xD,0xE into FIFO_DATA -> FIFO_STATUS=0x42, IRQ_STATUS=0x3. Pop 4 times -> 0xA..0xD. Fifth pop -> 0xf00df00d with empty=1. Write 0x2 to IRQ_STATUS -> reads 0x0.
- IRQ_EN=0x1, push 0x5 -> irq_o=1. Pop -> irq_o=0 one cycle later.
- Write CLOCK[1]=0x3F with sel=4'h7 -> no change (reads 0x1). Same write with sel=4'hF -> clock_op[11:6]=0x3F.
- Write PANIC with SWITCH=0x3 -> switch_out=0, IRQ_STATUS bit2=1. Writing SWITCH=0x3 again keeps switch_out=0; only reset restores 0x3.
- Drive val_in ch1=30'h3FFFFFFF and read VAL[1] -> 0x3FFFFFFF. Read BASE+0x100 -> no ack within 8 cycles. Assert reset on the request cycle -> no ack, no side effect.

Source files
------------

// File: rtl/wb_fibo_ctrl_if.sv
// Wishbone classic slave bus between the management core and wb_fibo_ctrl.
// Signal names keep the core-side wbs_* naming so both ends read the same.
interface wb_fibo_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_fibo_ctrl.sv
// Register window controlling NUM_CH Fibonacci channels: clock selects, enables,
// value readback, a mailbox FIFO, interrupt status/enable and a sticky panic.
module wb_fibo_ctrl #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          CLOCK_WIDTH  = 6,
    parameter int          NUM_CH       = 2,
    parameter int          VAL_WIDTH    = 30,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ID           = 32'h4669626f
) (
    input  logic                          wb_clk_i,
    input  logic                          reset,
    wb_fibo_ctrl_if.slave                 wbs,
    input  logic [NUM_CH*VAL_WIDTH-1:0]   val_in,
    output logic [NUM_CH*CLOCK_WIDTH-1:0] clock_op,
    output logic [NUM_CH-1:0]             switch_out,
    output logic                          irq_o
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] WIN_BYTES = 32'h20 + 32'(8 * NUM_CH);
    localparam logic [31:0] EMPTY_POP = 32'hf00d_f00d;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0]            offset;
    logic                   in_window;
    logic [5:0]             widx;
    logic                   req;
    logic                   wr_en;
    logic                   rd_en;
    logic                   push;
    logic                   pop;
    logic [31:0]            read_data;
    logic [31:0]            dat_reg;

    logic [2:0]             irq_en;
    logic [NUM_CH-1:0]      switch_reg;
    logic [CLOCK_WIDTH-1:0] clock_reg [NUM_CH];
    logic                   overflow;
    logic                   panic;

    logic [31:0]            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [2:0]             irq_status;

    assign offset     = wbs.wbs_adr_i - BASE_ADDRESS;
    assign in_window  = (wbs.wbs_adr_i >= BASE_ADDRESS) && (offset < WIN_BYTES);
    assign widx       = offset[7:2];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign irq_status = {panic, overflow, !fifo_empty};

    // A request is accepted only from idle, so a master holding stb across the
    // ack cycle does not trigger a second set of side effects.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wbs.wbs_stb_i && wbs.wbs_cyc_i && in_window) begin
                    req        = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_en = req && wbs.wbs_we_i && (wbs.wbs_sel_i == 4'hF);
    assign rd_en = req && !wbs.wbs_we_i;
    assign push  = wr_en && (widx == 6'd5);
    assign pop   = rd_en && (widx == 6'd5) && !fifo_empty;

    always_comb begin
        read_data = '0;
        case (widx)
            6'd0: read_data = {8'(NUM_CH), 8'(FIFO_DEPTH), 16'(8 + 2 * NUM_CH)};
            6'd1: read_data = ID;
            6'd2: read_data = {29'b0, irq_status};
            6'd3: read_data = {29'b0, irq_en};
            6'd4: read_data = 32'(switch_reg);
            6'd5: read_data = fifo_empty ? EMPTY_POP : fifo_mem[rd_ptr];
            6'd6: read_data = {23'b0, 5'(count), 2'b0, fifo_full, fifo_empty};
            6'd7: read_data = {31'b0, panic};
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (widx == 6'(8 + 2 * c))
                        read_data = 32'(clock_reg[c]);
                    if (widx == 6'(9 + 2 * c))
                        read_data = 32'(val_in[c*VAL_WIDTH +: VAL_WIDTH]);
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Read data is captured on the accepting edge and is zero outside the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (reset)
            dat_reg <= '0;
        else if (rd_en)
            dat_reg <= read_data;
        else
            dat_reg <= '0;
    end

    assign wbs.wbs_ack_o = (state == ST_ACK);
    assign wbs.wbs_dat_o = dat_reg;

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            irq_en     <= '0;
            switch_reg <= '1;
            overflow   <= 1'b0;
            panic      <= 1'b0;
            irq_o      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int c = 0; c < NUM_CH; c++)
                clock_reg[c] <= CLOCK_WIDTH'(1);
        end else begin
            irq_o <= |(irq_status & irq_en);
            if (wr_en) begin
                case (widx)
                    6'd2: if (wbs.wbs_dat_i[1]) overflow <= 1'b0;
                    6'd3: irq_en     <= wbs.wbs_dat_i[2:0];
                    6'd4: switch_reg <= wbs.wbs_dat_i[NUM_CH-1:0];
                    6'd7: panic      <= 1'b1;
                    default: ;
                endcase
                for (int c = 0; c < NUM_CH; c++)
                    if (widx == 6'(8 + 2 * c))
                        clock_reg[c] <= wbs.wbs_dat_i[CLOCK_WIDTH-1:0];
            end
            if (push) begin
                if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    count  <= count + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset && push && !fifo_full)
            fifo_mem[wr_ptr] <= wbs.wbs_dat_i;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_clock_op
        assign clock_op[c*CLOCK_WIDTH +: CLOCK_WIDTH] = clock_reg[c];
    end

    assign switch_out = panic ? '0 : switch_reg;

endmodule
